wb_regfile_slave: RTL and testbench

//  Wishbone B4 classic-cycle slave exposing a bank of NUM_REGS data registers.

---
 rtl/wb_regfile_pkg.sv | 22 ++
 rtl/wb_regfile_slave_if.sv | 28 ++
 rtl/wb_regfile_bank.sv | 45 ++++
 rtl/wb_regfile_slave.sv | 138 +++++++++++++
 tb/tb_wb_regfile_slave.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the Wishbone register-file slave: FSM encoding,
// write-counter limits and the saturating counter step.
package wb_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] RESP = ST_RESP;

  localparam int              WR_CNT_W   = 16;
  localparam logic [15:0]     WR_CNT_MAX = 16'hFFFF;

  function automatic logic [WR_CNT_W-1:0] wr_cnt_step(input logic [WR_CNT_W-1:0] cnt);
    return (cnt == WR_CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/wb_regfile_slave_if.sv
// Wishbone classic-cycle bus between a master and the register-file slave.
// Signal names follow the slave's point of view.
interface wb_regfile_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);

  logic                      cyc_i;
  logic                      stb_i;
  logic                      we_i;
  logic [ADDR_WIDTH-1:0]     adr_i;
  logic [DATA_WIDTH-1:0]     dat_i;
  logic [DATA_WIDTH/8-1:0]   sel_i;
  logic [DATA_WIDTH-1:0]     dat_o;
  logic                      ack_o;
  logic                      err_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_regfile_bank.sv
// Register array with a byte-enable synchronous write port and a
// combinational read port; addresses at or above NUM_REGS read as zero.
module wb_regfile_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_adr_i,
  input  logic [DATA_WIDTH-1:0]   wr_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wr_sel_i,
  input  logic [ADDR_WIDTH-1:0]   rd_adr_i,
  output logic [DATA_WIDTH-1:0]   rd_dat_o
);

  localparam int SEL_W = DATA_WIDTH / 8;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else if (wr_en_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < SEL_W; b++) begin
          if (wr_adr_i == ADDR_WIDTH'(r) && wr_sel_i[b]) begin
            regs_q[r][8*b +: 8] <= wr_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_dat_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_adr_i == ADDR_WIDTH'(r)) begin
        rd_dat_o = regs_q[r];
      end
    end
  end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone B4 classic-cycle slave: NUM_REGS data registers with byte selects,
// WAIT_STATES wait cycles, error response on unmapped words, acked-write counter.
module wb_regfile_slave
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_REGS    = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_regfile_slave_if.slave   wb,
  output logic [WR_CNT_W-1:0] wr_cnt_o
);

  localparam int                  SEL_W      = DATA_WIDTH / 8;
  localparam int                  CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic [1:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q,    adr_d;
  logic                  we_q,     we_d;
  logic [DATA_WIDTH-1:0] wdat_q,   wdat_d;
  logic [SEL_W-1:0]      sel_q,    sel_d;
  logic                  ack_q,    ack_d;
  logic                  err_q,    err_d;
  logic [DATA_WIDTH-1:0] rdat_q,   rdat_d;
  logic [WR_CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic                  hit;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] bank_rdat;

  assign hit = ({1'b0, adr_q} < NUM_REGS_W);

  wb_regfile_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_bank (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en),
    .wr_adr_i (adr_q),
    .wr_dat_i (wdat_q),
    .wr_sel_i (sel_q),
    .rd_adr_i (adr_q),
    .rd_dat_o (bank_rdat)
  );

  // Every request passes through WAIT (even with zero wait states) so the
  // response always lands WAIT_STATES+1 edges after acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    wr_cnt_d = wr_cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb.cyc_i && wb.stb_i) begin
          adr_d   = wb.adr_i;
          we_d    = wb.we_i;
          wdat_d  = wb.dat_i;
          sel_d   = wb.sel_i;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!wb.cyc_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          if (hit) begin
            ack_d = 1'b1;
            if (we_q) begin
              wr_en    = 1'b1;
              wr_cnt_d = wr_cnt_step(wr_cnt_q);
            end else begin
              rdat_d = bank_rdat;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // stb is deliberately ignored here so a master releasing stb one cycle
      // after ack cannot start a second transfer.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      sel_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdat_q   <= rdat_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.dat_o = rdat_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Bench for wb_regfile_slave: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_wb_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 12;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [15:0] wr_cnt0, wr_cnt1;

  always #5 clk = ~clk;

  wb_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  wb_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  wb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(WS)) dut0 (
    .clk_i(clk), .rst_i(rst0), .wb(b0.slave), .wr_cnt_o(wr_cnt0));

  wb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(0)) dut1 (
    .clk_i(clk), .rst_i(rst1), .wb(b1.slave), .wr_cnt_o(wr_cnt1));

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_regs [NR];
  int          model_cnt;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    model_cnt = 0;
  endtask

  task automatic model_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (adr < NR) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) model_regs[adr][8*b +: 8] = dat[8*b +: 8];
      model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
    end
  endtask

  // One transfer on dut0 with the master keeping cyc/stb up one cycle past ack.
  task automatic xfer0(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit scramble,
                       output int lat, output logic ack, output logic err,
                       output logic [31:0] rd, output logic dbl);
    @(negedge clk);
    b0.cyc_i = 1'b1; b0.stb_i = 1'b1; b0.we_i = we;
    b0.adr_i = adr;  b0.dat_i = dat;  b0.sel_i = sel;
    @(posedge clk);
    if (scramble) begin
      #1;
      b0.we_i = 1'($urandom); b0.adr_i = 4'($urandom);
      b0.dat_i = $urandom;    b0.sel_i = 4'($urandom);
    end
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b0.ack_o || b0.err_o) begin
        lat = k; ack = b0.ack_o; err = b0.err_o; rd = b0.dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    dbl = b0.ack_o | b0.err_o;
    b0.cyc_i = 1'b0; b0.stb_i = 1'b0;
  endtask

  task automatic xfer1(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       output int lat, output logic [31:0] rd);
    @(negedge clk);
    b1.cyc_i = 1'b1; b1.stb_i = 1'b1; b1.we_i = we;
    b1.adr_i = adr;  b1.dat_i = dat;  b1.sel_i = 4'hF;
    @(posedge clk);
    lat = -1; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b1.ack_o) begin lat = k; rd = b1.dat_o; break; end
    end
    @(posedge clk); #1;
    b1.cyc_i = 1'b0; b1.stb_i = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (b0.ack_o !== 1'b0) $display("FAIL rst_ack got=%b exp=0", b0.ack_o); else n_pass++;
    n_total++; if (b0.err_o !== 1'b0) $display("FAIL rst_err got=%b exp=0", b0.err_o); else n_pass++;
    n_total++; if (b0.dat_o !== 32'h0) $display("FAIL rst_dat got=%h exp=0", b0.dat_o); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'h0) $display("FAIL rst_wrcnt got=%h exp=0", wr_cnt0); else n_pass++;
    n_total++; if (wr_cnt1 !== 16'h0) $display("FAIL rst_wrcnt1 got=%h exp=0", wr_cnt1); else n_pass++;
  endtask

  task automatic test_basic();
    int lat; logic ack, err, dbl; logic [31:0] rd;
    xfer0(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    model_write(4'd3, 32'hDEADBEEF, 4'hF);
    n_total++; if (lat !== 3) $display("FAIL t1_wr_lat got=%0d exp=3", lat); else n_pass++;
    n_total++; if (ack !== 1'b1 || err !== 1'b0) $display("FAIL t1_wr_ack got=%b%b exp=10", ack, err); else n_pass++;
    xfer0(1'b0, 4'd3, 32'h0, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    n_total++; if (lat !== 3) $display("FAIL t1_rd_lat got=%0d exp=3", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL t1_rd_dat got=%h exp=deadbeef", rd); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'd1) $display("FAIL t1_wrcnt got=%0d exp=1", wr_cnt0); else n_pass++;
  endtask

  task automatic test_byte_sel();
    int lat; logic ack, err, dbl; logic [31:0] rd;
    xfer0(1'b1, 4'd3, 32'h0000AA00, 4'b0010, 1'b0, lat, ack, err, rd, dbl);
    model_write(4'd3, 32'h0000AA00, 4'b0010);
    xfer0(1'b0, 4'd3, 32'h0, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    n_total++; if (rd !== 32'hDEADAAEF) $display("FAIL t2_rd_dat got=%h exp=deadaaef", rd); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'd2) $display("FAIL t2_wrcnt got=%0d exp=2", wr_cnt0); else n_pass++;
  endtask

  task automatic test_unmapped();
    int lat; logic ack, err, dbl; logic [31:0] rd;
    xfer0(1'b1, 4'd12, 32'h12345678, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    n_total++; if (ack !== 1'b0 || err !== 1'b1) $display("FAIL t3_wr_err got=%b%b exp=01", ack, err); else n_pass++;
    n_total++; if (dbl !== 1'b0) $display("FAIL t3_err_pulse got=%b exp=0", dbl); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'(model_cnt)) $display("FAIL t3_wrcnt got=%0d exp=%0d", wr_cnt0, model_cnt); else n_pass++;
    xfer0(1'b0, 4'd12, 32'h0, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    n_total++; if (ack !== 1'b0 || err !== 1'b1) $display("FAIL t3_rd_err got=%b%b exp=01", ack, err); else n_pass++;
    n_total++; if (rd !== 32'h0) $display("FAIL t3_rd_dat got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_abort();
    int lat; logic ack, err, dbl; logic [31:0] rd; logic seen;
    int cnt_before = model_cnt;
    @(negedge clk);
    b0.cyc_i = 1'b1; b0.stb_i = 1'b1; b0.we_i = 1'b1;
    b0.adr_i = 4'd5; b0.dat_i = ~model_regs[5]; b0.sel_i = 4'hF;
    @(posedge clk); #1;
    b0.cyc_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | b0.ack_o | b0.err_o; end
    b0.stb_i = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL t4_abort_resp got=%b exp=0", seen); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'(cnt_before)) $display("FAIL t4_wrcnt got=%0d exp=%0d", wr_cnt0, cnt_before); else n_pass++;
    xfer0(1'b0, 4'd5, 32'h0, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    n_total++; if (lat !== 3 || ack !== 1'b1) $display("FAIL t4_next_ack got=lat%0d/%b exp=lat3/1", lat, ack); else n_pass++;
    n_total++; if (rd !== model_regs[5]) $display("FAIL t4_reg got=%h exp=%h", rd, model_regs[5]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic ack, err, dbl; logic [31:0] rd; logic seen;
    int cnt_before = model_cnt;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] d = $urandom;
      xfer0(1'b1, 4'(i + 8), d, 4'hF, 1'b0, lat, ack, err, rd, dbl);
      model_write(4'(i + 8), d, 4'hF);
      n_total++; if (dbl !== 1'b0) $display("FAIL t6_single_ack[%0d] got=%b exp=0", i, dbl); else n_pass++;
    end
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen = seen | b0.ack_o; end
    n_total++; if (seen !== 1'b0) $display("FAIL t6_stray_ack got=%b exp=0", seen); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'(cnt_before + 2)) $display("FAIL t6_wrcnt got=%0d exp=%0d", wr_cnt0, cnt_before + 2); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic ack, err, dbl; logic [31:0] rd, exp_rd;
    logic we; logic [3:0] adr, sel; logic [31:0] dat; bit sc, hit;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); adr = 4'($urandom_range(0, 15));
      dat = $urandom; sel = 4'($urandom_range(0, 15)); sc = 1'($urandom_range(0, 1));
      hit = (adr < NR);
      exp_rd = hit ? model_regs[adr] : 32'h0;
      xfer0(we, adr, dat, sel, sc, lat, ack, err, rd, dbl);
      if (we) model_write(adr, dat, sel);
      n_total++; if (lat !== WS + 1) $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, WS + 1); else n_pass++;
      n_total++; if (ack !== hit || err !== !hit) $display("FAIL rnd_resp[%0d] got=%b%b exp=%b%b", i, ack, err, hit, !hit); else n_pass++;
      if (!we) begin
        n_total++; if (rd !== exp_rd) $display("FAIL rnd_rdat[%0d] adr=%0d got=%h exp=%h", i, adr, rd, exp_rd); else n_pass++;
      end
      n_total++; if (dbl !== 1'b0) $display("FAIL rnd_pulse[%0d] got=%b exp=0", i, dbl); else n_pass++;
      n_total++; if (wr_cnt0 !== 16'(model_cnt)) $display("FAIL rnd_wrcnt[%0d] got=%0d exp=%0d", i, wr_cnt0, model_cnt); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int lat; logic ack, err, dbl; logic [31:0] rd; logic ack_pre;
    @(negedge clk);
    b0.cyc_i = 1'b1; b0.stb_i = 1'b1; b0.we_i = 1'b0; b0.adr_i = 4'd3;
    @(posedge clk); @(posedge clk); #3;
    rst0 = 1'b1; #1;
    n_total++; if (b0.ack_o !== 1'b0) $display("FAIL t5_wait_ack got=%b exp=0", b0.ack_o); else n_pass++;
    n_total++; if (wr_cnt0 !== 16'h0) $display("FAIL t5_wait_wrcnt got=%0d exp=0", wr_cnt0); else n_pass++;
    b0.cyc_i = 1'b0; b0.stb_i = 1'b0;
    @(negedge clk); rst0 = 1'b0;
    model_clear();
    xfer0(1'b1, 4'd4, 32'hCAFEF00D, 4'hF, 1'b0, lat, ack, err, rd, dbl);
    @(negedge clk);
    b0.cyc_i = 1'b1; b0.stb_i = 1'b1; b0.we_i = 1'b0; b0.adr_i = 4'd4;
    @(posedge clk);
    ack_pre = 1'b0;
    for (int k = 0; k < 20 && !ack_pre; k++) begin @(posedge clk); #1; ack_pre = b0.ack_o; end
    n_total++; if (ack_pre !== 1'b1) $display("FAIL t5_resp_reached got=%b exp=1", ack_pre); else n_pass++;
    #2; rst0 = 1'b1; #1;
    n_total++; if (b0.ack_o !== 1'b0 || b0.dat_o !== 32'h0) $display("FAIL t5_resp_clear got=%b/%h exp=0/0", b0.ack_o, b0.dat_o); else n_pass++;
    b0.cyc_i = 1'b0; b0.stb_i = 1'b0;
    @(negedge clk); rst0 = 1'b0;
    for (int r = 0; r < NR; r++) begin
      xfer0(1'b0, 4'(r), 32'h0, 4'hF, 1'b0, lat, ack, err, rd, dbl);
      n_total++; if (rd !== 32'h0 || ack !== 1'b1) $display("FAIL t5_reg[%0d] got=%h/%b exp=0/1", r, rd, ack); else n_pass++;
    end
    n_total++; if (wr_cnt0 !== 16'h0) $display("FAIL t5_wrcnt got=%0d exp=0", wr_cnt0); else n_pass++;
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic [31:0] d = $urandom;
    xfer1(1'b1, 4'd7, d, lat, rd);
    n_total++; if (lat !== 1) $display("FAIL t5_ws0_wr_lat got=%0d exp=1", lat); else n_pass++;
    xfer1(1'b0, 4'd7, 32'h0, lat, rd);
    n_total++; if (lat !== 1) $display("FAIL t5_ws0_rd_lat got=%0d exp=1", lat); else n_pass++;
    n_total++; if (rd !== d) $display("FAIL t5_ws0_rd_dat got=%h exp=%h", rd, d); else n_pass++;
    n_total++; if (wr_cnt1 !== 16'd1) $display("FAIL t5_ws0_wrcnt got=%0d exp=1", wr_cnt1); else n_pass++;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.cyc_i = 1'b0; b0.stb_i = 1'b0; b0.we_i = 1'b0; b0.adr_i = '0; b0.dat_i = '0; b0.sel_i = '0;
    b1.cyc_i = 1'b0; b1.stb_i = 1'b0; b1.we_i = 1'b0; b1.adr_i = '0; b1.dat_i = '0; b1.sel_i = '0;
    model_clear();
    #22;
    test_reset();
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;
    test_basic();
    test_byte_sel();
    test_unmapped();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_zero_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
